// File: rtl/fxp_pkg.sv
// Shared Q10.22 fixed-point parameters for the multiplier and dot-product reduction stages.
package fxp_pkg;

  localparam int unsigned WORD_LEN   = 32;
  localparam int unsigned MATRIX_DIM = 8;
  localparam int unsigned FRAC_BITS  = 22;
  localparam int unsigned ACC_W      = 40;

  // Each adder-tree level grows the sum by one bit.
  function automatic int unsigned tree_w(input int unsigned word_len, input int unsigned level);
    return word_len + level;
  endfunction

  localparam int unsigned S1_W = tree_w(WORD_LEN, 1);
  localparam int unsigned S2_W = tree_w(WORD_LEN, 2);
  localparam int unsigned S3_W = tree_w(WORD_LEN, 3);

endpackage

// File: rtl/fxp_sat.sv
// Clips a signed accumulator value to the signed WORD_LEN output range and flags clipping.
module fxp_sat #(
  parameter int unsigned ACC_W    = fxp_pkg::ACC_W,
  parameter int unsigned WORD_LEN = fxp_pkg::WORD_LEN
) (
  input  logic signed [ACC_W-1:0]    value,
  output logic        [WORD_LEN-1:0] data,
  output logic                       sat
);

  // Bits above the output sign bit must all equal it for the value to fit.
  logic [ACC_W-WORD_LEN:0] top_bits;

  always_comb begin
    top_bits = value[ACC_W-1:WORD_LEN-1];
    sat      = !((top_bits == '0) || (top_bits == '1));
    if (!sat)
      data = value[WORD_LEN-1:0];
    else if (value[ACC_W-1])
      data = {1'b1, {(WORD_LEN-1){1'b0}}};
    else
      data = {1'b0, {(WORD_LEN-1){1'b1}}};
  end

endmodule

// File: rtl/fxp_dot_reduce.sv
// Dot-product reduction: 3-level adder tree over 8 Q10.22 lanes, then a saturating
// per-vector accumulator with a valid/ready result port and a global stall.
module fxp_dot_reduce #(
  parameter int unsigned WORD_LEN   = fxp_pkg::WORD_LEN,
  parameter int unsigned MATRIX_DIM = fxp_pkg::MATRIX_DIM,
  parameter int unsigned FRAC_BITS  = fxp_pkg::FRAC_BITS,
  parameter int unsigned ACC_W      = fxp_pkg::ACC_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WORD_LEN*MATRIX_DIM-1:0] in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [WORD_LEN-1:0]            out_data,
  output logic                           out_sat,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [15:0]                    vec_cnt
);

  import fxp_pkg::*;

  localparam int unsigned T1_W = tree_w(WORD_LEN, 1);
  localparam int unsigned T2_W = tree_w(WORD_LEN, 2);
  localparam int unsigned T3_W = tree_w(WORD_LEN, 3);

  // The tree is hard-wired for eight lanes; lanes share one Q format so no alignment is done.
  if (MATRIX_DIM != 8 || FRAC_BITS >= WORD_LEN || ACC_W < T3_W) begin : g_bad_params
    $error("fxp_dot_reduce: unsupported parameterisation");
  end

  logic                       adv;
  logic signed [WORD_LEN-1:0] lane [MATRIX_DIM];

  logic signed [T1_W-1:0] s1_sum [4];
  logic signed [T2_W-1:0] s2_sum [2];
  logic signed [T3_W-1:0] s3_sum;
  logic                   s1_valid, s2_valid, s3_valid;
  logic                   s1_last,  s2_last,  s3_last;

  logic signed [ACC_W-1:0]    acc;
  logic                       first;
  logic signed [ACC_W-1:0]    beat_sum;
  logic signed [ACC_W-1:0]    total;
  logic        [WORD_LEN-1:0] sat_data;
  logic                       sat_flag;

  always_comb begin
    for (int unsigned k = 0; k < MATRIX_DIM; k++)
      lane[k] = in_data[k*WORD_LEN +: WORD_LEN];
  end

  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
  end

  always_comb begin
    beat_sum = ACC_W'(s3_sum);
    total    = first ? beat_sum : acc + beat_sum;
  end

  fxp_sat #(
    .ACC_W    (ACC_W),
    .WORD_LEN (WORD_LEN)
  ) u_sat (
    .value (total),
    .data  (sat_data),
    .sat   (sat_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) s1_sum[i] <= '0;
      for (int unsigned i = 0; i < 2; i++) s2_sum[i] <= '0;
      s3_sum    <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_last   <= 1'b0;
      s3_last   <= 1'b0;
      acc       <= '0;
      first     <= 1'b1;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      for (int unsigned i = 0; i < 4; i++)
        s1_sum[i] <= T1_W'(lane[2*i]) + T1_W'(lane[2*i+1]);
      for (int unsigned i = 0; i < 2; i++)
        s2_sum[i] <= T2_W'(s1_sum[2*i]) + T2_W'(s1_sum[2*i+1]);
      s3_sum   <= T3_W'(s2_sum[0]) + T3_W'(s2_sum[1]);
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      s1_last  <= in_valid && in_last;
      s2_last  <= s1_last;
      s3_last  <= s2_last;

      if (s3_valid && s3_last) begin
        out_data  <= sat_data;
        out_sat   <= sat_flag;
        out_valid <= 1'b1;
        acc       <= '0;
        first     <= 1'b1;
      end else begin
        out_valid <= 1'b0;
        if (s3_valid) begin
          acc   <= total;
          first <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vec_cnt <= '0;
    else if (out_valid && out_ready)
      vec_cnt <= vec_cnt + 16'd1;
  end

endmodule

// File: doc/fxp_dot_reduce.md
FXP_DOT_REDUCE -- requirements
Module: fxp_dot_reduce

Interface
REQ-001 The block SHALL have parameter WORD_LEN, default 32, the lane width in bits (signed Q10.22).
REQ-002 The block SHALL have parameter MATRIX_DIM, default 8, the lanes per beat.
REQ-003 The block SHALL have parameter FRAC_BITS, default 22, the fractional bits per lane.
REQ-004 The block SHALL have parameter ACC_W, default 40, the accumulator width.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset: clk input 1 (rising edge), rst_n input 1.
REQ-006 The block SHALL have port in_data, input, WORD_LEN*MATRIX_DIM: packed signed lanes, lane k at [32k+31:32k], from the multiplier stage.
REQ-007 The block SHALL have port in_valid, input, 1: beat valid.
REQ-008 The block SHALL have port in_last, input, 1: final beat of the current dot product.
REQ-009 The block SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-010 The block SHALL have port out_data, output, WORD_LEN: saturated Q10.22 dot-product result.
REQ-011 The block SHALL have port out_sat, output, 1: out_data was clipped.
REQ-012 The block SHALL have port out_valid, output, 1, and port out_ready, input, 1, forming a valid/ready result handshake.
REQ-013 The block SHALL have port vec_cnt, output, 16: completed results, wrapping at 0xFFFF->0x0000.

Function
REQ-014 The block SHALL register stage 1 as four pairwise lane sums, 33 bits, sign-extended.
REQ-015 The block SHALL register stage 2 as two sums, 34 bits.
REQ-016 The block SHALL register stage 3 as one sum, 35 bits, carrying the beat's last flag and valid.
REQ-017 The block SHALL implement stage 4 as an accumulator: on a valid stage-3 beat, acc = (first beat ? sum : acc + sum), sign-extended to ACC_W; no rounding or shifting, since lanes share one Q format.
REQ-018 When stage 3 carries last, the block SHALL load the output register with sat(acc + sum), set out_valid=1, and clear acc so the next beat is a first beat.
REQ-019 Saturation SHALL clip to the range 0x80000000..0x7FFFFFFF; out_sat=1 exactly when clipping occurred.
REQ-020 All stages SHALL advance on adv = !out_valid || out_ready, so in_ready = adv (a global stall).
REQ-021 When adv=0, all stage registers and acc SHALL hold, and no beat SHALL be lost or duplicated.
REQ-022 Latency: a single-beat vector accepted at cycle N with no stall SHALL show out_valid=1 at cycle N+4.
REQ-023 Throughput SHALL be one beat per cycle with out_ready held high.
REQ-024 out_data, out_sat and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-025 out_valid SHALL deassert after the handshake unless a new result loads in the same cycle; back-to-back results SHALL be allowed.
REQ-026 vec_cnt SHALL increment on each out_valid && out_ready.
REQ-027 Pipeline bubbles (in_valid=0) SHALL propagate as invalid stages and leave acc unchanged.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously hold all stage valids at 0, acc=0, first-beat flag=1, out_valid=0, out_data=0, out_sat=0, vec_cnt=0.
REQ-029 Reset asserted mid-vector SHALL discard partial accumulation, and no result SHALL be emitted for that vector.
REQ-030 in_ready SHALL equal 1 in the first cycle after reset release.

Structure
REQ-031 WORD_LEN, MATRIX_DIM, FRAC_BITS, ACC_W and the tree-stage widths SHALL live in a shared package, fxp_pkg, also used by the multiplier stage.
REQ-032 Saturation SHALL be one combinational sub-module, fxp_sat (ACC_W in, WORD_LEN out, sat flag).

Verification
REQ-033 All lanes 0x00400000 (1.0), in_last=1 -> out_data=0x02000000 (8.0) at cycle N+4, out_sat=0.
REQ-034 Lanes alternating 0x00400000/0xFFC00000, in_last=1 -> out_data=0x00000000.
REQ-035 Two-beat vector: beat 1 all 0x00200000 with last=0, beat 2 all 0x00100000 with last=1 -> a single result 0x01800000 (6.0).
REQ-036 All lanes 0x7FFFFFFF, last=1 -> out_data=0x7FFFFFFF, out_sat=1; all lanes 0x80000000 -> out_data=0x80000000, out_sat=1.
REQ-037 Ten continuous single-beat vectors with out_ready low for cycles 5-9 -> in_ready falls, results stay in order and stable while stalled, none lost, vec_cnt=10.
REQ-038 rst_n pulsed low after beat 1 of a two-beat vector -> no output, then a fresh 1.0-lane vector yields 0x02000000.
